// File: rtl/weight_fetch_control_unit_pkg.sv
// Shared types and defaults for the weight-fetch sequencer that feeds the
// systolic MAC array's ping/pong weight buffers.
package weight_fetch_control_unit_pkg;

  localparam int MUL_SIZE      = 32;
  localparam int WEIGHT_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_FREE,
    DRAIN
  } weight_fetch_state_t;

  typedef logic [$clog2(MUL_SIZE)-1:0] row_idx_t;

endpackage

// File: rtl/weight_fetch_control_unit.sv
// Streams weight tiles row by row from weight memory into the ping/pong MAC
// weight buffers, keeping at most two tiles resident ahead of compute.
module weight_fetch_control_unit #(
  parameter int MUL_SIZE = weight_fetch_control_unit_pkg::MUL_SIZE,
  parameter int ADDR_W   = weight_fetch_control_unit_pkg::WEIGHT_ADDR_W,
  parameter int TILES_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ADDR_W-1:0]           W_base_addr_i,
  input  logic [TILES_W-1:0]          num_tiles_i,
  input  logic                        next_weight_tile_i,
  output logic                        weight_rd_en_o,
  output logic [ADDR_W-1:0]           weight_rd_addr_o,
  output logic                        weight_wr_en_o,
  output logic [$clog2(MUL_SIZE)-1:0] weight_wr_row_o,
  output logic                        weight_wr_buf_o,
  output logic                        compute_weights_rdy_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        underflow_o
);
  import weight_fetch_control_unit_pkg::*;

  localparam int ROW_W = $clog2(MUL_SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

  weight_fetch_state_t state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [TILES_W-1:0]  num_tiles_q;
  logic [TILES_W-1:0]  tile_cntr;
  logic [ROW_W-1:0]    row_cntr;
  logic                buf_ptr;
  logic [1:0]          reserved_q;
  logic [1:0]          full_q;

  logic               consume_seen;
  logic               consume_valid;
  logic               full_inc;
  logic               last_row;
  logic               last_tile;
  logic               reserve_inc;
  logic [TILES_W-1:0] tile_next;
  logic [1:0]         reserved_after;
  logic [1:0]         reserved_d;
  logic [1:0]         full_d;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [TILES_W-1:0] tile);
    return base_q + (ADDR_W'(tile) << ROW_W);
  endfunction

  // A consume only counts when a fully written tile exists; row_cntr/buf_ptr
  // always describe the read currently presented to memory.
  always_comb begin
    consume_seen   = next_weight_tile_i && (state_q != IDLE);
    consume_valid  = consume_seen && (full_q != 2'd0);
    full_inc       = weight_wr_en_o && (weight_wr_row_o == LAST_ROW);
    last_row       = (state_q == FETCH) && (row_cntr == LAST_ROW);
    tile_next      = tile_cntr + TILES_W'(1);
    last_tile      = last_row && (tile_next == num_tiles_q);
    reserved_after = reserved_q - {1'b0, consume_valid};
    reserve_inc    = ((state_q == IDLE) && start_i && (num_tiles_i != '0))
                   || (last_row && !last_tile && (reserved_after != 2'd2))
                   || ((state_q == WAIT_FREE) && consume_valid);
    reserved_d     = reserved_after + {1'b0, reserve_inc};
    full_d         = full_q + {1'b0, full_inc} - {1'b0, consume_valid};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q               <= IDLE;
      base_q                <= '0;
      num_tiles_q           <= '0;
      tile_cntr             <= '0;
      row_cntr              <= '0;
      buf_ptr               <= 1'b0;
      reserved_q            <= 2'd0;
      full_q                <= 2'd0;
      weight_rd_en_o        <= 1'b0;
      weight_rd_addr_o      <= '0;
      weight_wr_en_o        <= 1'b0;
      weight_wr_row_o       <= '0;
      weight_wr_buf_o       <= 1'b0;
      compute_weights_rdy_o <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      underflow_o           <= 1'b0;
    end else begin
      done_o                <= 1'b0;
      weight_wr_en_o        <= weight_rd_en_o;
      weight_wr_row_o       <= row_cntr;
      weight_wr_buf_o       <= buf_ptr;
      reserved_q            <= reserved_d;
      full_q                <= full_d;
      compute_weights_rdy_o <= (full_d != 2'd0);
      if (consume_seen && (full_q == 2'd0)) underflow_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q      <= W_base_addr_i;
            num_tiles_q <= num_tiles_i;
            underflow_o <= 1'b0;
            tile_cntr   <= '0;
            row_cntr    <= '0;
            buf_ptr     <= 1'b0;
            if (num_tiles_i != '0) begin
              state_q          <= FETCH;
              busy_o           <= 1'b1;
              weight_rd_en_o   <= 1'b1;
              weight_rd_addr_o <= W_base_addr_i;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        // Tile boundary: hop straight into the next tile if a buffer is free.
        FETCH: begin
          if (last_row) begin
            row_cntr  <= '0;
            tile_cntr <= tile_next;
            buf_ptr   <= ~buf_ptr;
            if (last_tile) begin
              state_q        <= DRAIN;
              weight_rd_en_o <= 1'b0;
            end else if (reserved_after != 2'd2) begin
              weight_rd_en_o   <= 1'b1;
              weight_rd_addr_o <= tile_addr(tile_next);
            end else begin
              state_q        <= WAIT_FREE;
              weight_rd_en_o <= 1'b0;
            end
          end else begin
            row_cntr         <= row_cntr + ROW_W'(1);
            weight_rd_addr_o <= weight_rd_addr_o + ADDR_W'(1);
          end
        end
        WAIT_FREE: begin
          if (consume_valid) begin
            state_q          <= FETCH;
            weight_rd_en_o   <= 1'b1;
            weight_rd_addr_o <= tile_addr(tile_cntr);
          end
        end
        DRAIN: begin
          if ((full_q == 2'd0) && !weight_wr_en_o) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_control_unit.sv
// Bench for weight_fetch_control_unit: directed tables and sequences plus a
// randomized run, all against a row-stream reference model.
module tb_weight_fetch_control_unit;

  localparam int MUL = 32;
  localparam int AW  = 16;
  localparam int TW  = 8;
  localparam int RW  = $clog2(MUL);
  localparam int NVEC = 9;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] W_base_addr_i = '0;
  logic [TW-1:0] num_tiles_i = '0;
  logic          next_weight_tile_i = 1'b0;
  logic          weight_rd_en_o;
  logic [AW-1:0] weight_rd_addr_o;
  logic          weight_wr_en_o;
  logic [RW-1:0] weight_wr_row_o;
  logic          weight_wr_buf_o;
  logic          compute_weights_rdy_o;
  logic          busy_o;
  logic          done_o;
  logic          underflow_o;

  always #5 clk_i = ~clk_i;

  weight_fetch_control_unit #(.MUL_SIZE(MUL), .ADDR_W(AW), .TILES_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .W_base_addr_i(W_base_addr_i), .num_tiles_i(num_tiles_i),
    .next_weight_tile_i(next_weight_tile_i),
    .weight_rd_en_o(weight_rd_en_o), .weight_rd_addr_o(weight_rd_addr_o),
    .weight_wr_en_o(weight_wr_en_o), .weight_wr_row_o(weight_wr_row_o),
    .weight_wr_buf_o(weight_wr_buf_o),
    .compute_weights_rdy_o(compute_weights_rdy_o),
    .busy_o(busy_o), .done_o(done_o), .underflow_o(underflow_o)
  );

  int err_count = 0;
  int check_count = 0;

  // Reference model: reads form one global row stream g = tile*MUL + row;
  // a new tile may start only while fewer than two tiles are held unconsumed.
  bit            m_busy, m_pres, m_wr, m_done, m_rdy, m_underflow;
  int            m_pres_g, m_wr_g, m_full, m_started, m_consumed, m_num;
  logic [AW-1:0] m_base;

  typedef struct {
    int            cyc;
    bit            rd;
    logic [AW-1:0] addr;
    bit            wr;
    int            row;
    bit            bsel;
    bit            rdy;
    bit            busy;
    bit            done;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic expectVal(input string name, input int act, input int exp);
    check_count++;
    if (act != exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic modelEdge();
    bit seen, valid, inc, nxt_pres, nxt_done;
    int nxt_g;
    if (!rst_i) begin
      m_busy = 0; m_pres = 0; m_wr = 0; m_done = 0; m_rdy = 0; m_underflow = 0;
      m_pres_g = 0; m_wr_g = 0; m_full = 0; m_started = 0; m_consumed = 0;
      m_num = 0; m_base = '0;
      return;
    end
    seen     = next_weight_tile_i && m_busy;
    valid    = seen && (m_full > 0);
    inc      = m_wr && ((m_wr_g % MUL) == MUL - 1);
    nxt_pres = 0;
    nxt_g    = m_pres_g;
    nxt_done = 0;
    if (m_busy) begin
      if (m_pres && ((m_pres_g % MUL) != MUL - 1)) begin
        nxt_pres = 1;
        nxt_g    = m_pres_g + 1;
      end else if (m_started < m_num && (m_started - m_consumed - int'(valid)) < 2) begin
        nxt_pres = 1;
        nxt_g    = m_started * MUL;
        m_started++;
      end else if (!m_pres && m_started == m_num && m_full == 0 && !m_wr) begin
        nxt_done = 1;
        m_busy   = 0;
      end
    end else if (start_i) begin
      m_base      = W_base_addr_i;
      m_num       = int'(num_tiles_i);
      m_underflow = 0;
      m_started   = 0;
      m_consumed  = 0;
      if (m_num != 0) begin
        m_busy    = 1;
        nxt_pres  = 1;
        nxt_g     = 0;
        m_started = 1;
      end else begin
        nxt_done = 1;
      end
    end
    if (seen && m_full == 0) m_underflow = 1;
    m_consumed += int'(valid);
    m_full     += int'(inc) - int'(valid);
    m_wr        = m_pres;
    m_wr_g      = m_pres_g;
    m_pres      = nxt_pres;
    m_pres_g    = nxt_g;
    m_done      = nxt_done;
    m_rdy       = (m_full > 0);
  endtask

  task automatic checkOutput();
    logic [AW-1:0] exp_addr;
    exp_addr = m_base + AW'(m_pres_g);
    expectVal("rd_en", int'(weight_rd_en_o), int'(m_pres));
    if (m_pres) expectVal("rd_addr", int'(weight_rd_addr_o), int'(exp_addr));
    expectVal("wr_en", int'(weight_wr_en_o), int'(m_wr));
    if (m_wr) begin
      expectVal("wr_row", int'(weight_wr_row_o), m_wr_g % MUL);
      expectVal("wr_buf", int'(weight_wr_buf_o), (m_wr_g / MUL) % 2);
    end
    expectVal("rdy", int'(compute_weights_rdy_o), int'(m_rdy));
    expectVal("busy", int'(busy_o), int'(m_busy));
    expectVal("done", int'(done_o), int'(m_done));
    expectVal("underflow", int'(underflow_o), int'(m_underflow));
  endtask

  task automatic applyStimulus();
    @(posedge clk_i);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic checkVector(input vec_t v);
    expectVal("tbl_rd_en", int'(weight_rd_en_o), int'(v.rd));
    if (v.rd) expectVal("tbl_rd_addr", int'(weight_rd_addr_o), int'(v.addr));
    expectVal("tbl_wr_en", int'(weight_wr_en_o), int'(v.wr));
    if (v.wr) begin
      expectVal("tbl_wr_row", int'(weight_wr_row_o), v.row);
      expectVal("tbl_wr_buf", int'(weight_wr_buf_o), int'(v.bsel));
    end
    expectVal("tbl_rdy", int'(compute_weights_rdy_o), int'(v.rdy));
    expectVal("tbl_busy", int'(busy_o), int'(v.busy));
    expectVal("tbl_done", int'(done_o), int'(v.done));
  endtask

  task automatic doReset();
    rst_i = 1'b0;
    start_i = 1'b0;
    next_weight_tile_i = 1'b0;
    applyStimulus();
    applyStimulus();
    rst_i = 1'b1;
  endtask

  // The start edge is cycle 0; afterwards the outputs seen are cycle 1's.
  task automatic startRun(input logic [AW-1:0] base, input logic [TW-1:0] num);
    W_base_addr_i = base;
    num_tiles_i   = num;
    start_i       = 1'b1;
    applyStimulus();
    start_i       = 1'b0;
  endtask

  initial begin
    int contig, idle_rd, rdy_high, busy_seen, done_seen;

    vecs[0] = '{cyc: 1,  rd: 1, addr: 16'h0100, wr: 0, row: 0,  bsel: 0, rdy: 0, busy: 1, done: 0};
    vecs[1] = '{cyc: 2,  rd: 1, addr: 16'h0101, wr: 1, row: 0,  bsel: 0, rdy: 0, busy: 1, done: 0};
    vecs[2] = '{cyc: 32, rd: 1, addr: 16'h011F, wr: 1, row: 30, bsel: 0, rdy: 0, busy: 1, done: 0};
    vecs[3] = '{cyc: 33, rd: 0, addr: 16'h0000, wr: 1, row: 31, bsel: 0, rdy: 0, busy: 1, done: 0};
    vecs[4] = '{cyc: 34, rd: 0, addr: 16'h0000, wr: 0, row: 0,  bsel: 0, rdy: 1, busy: 1, done: 0};
    vecs[5] = '{cyc: 40, rd: 0, addr: 16'h0000, wr: 0, row: 0,  bsel: 0, rdy: 1, busy: 1, done: 0};
    vecs[6] = '{cyc: 41, rd: 0, addr: 16'h0000, wr: 0, row: 0,  bsel: 0, rdy: 0, busy: 1, done: 0};
    vecs[7] = '{cyc: 42, rd: 0, addr: 16'h0000, wr: 0, row: 0,  bsel: 0, rdy: 0, busy: 0, done: 1};
    vecs[8] = '{cyc: 43, rd: 0, addr: 16'h0000, wr: 0, row: 0,  bsel: 0, rdy: 0, busy: 0, done: 0};

    // Single tile, consumed at cycle 40
    doReset();
    startRun(16'h0100, 8'd1);
    for (int c = 1; c <= 43; c++) begin
      for (int i = 0; i < NVEC; i++) if (vecs[i].cyc == c) checkVector(vecs[i]);
      next_weight_tile_i = (c == 40);
      applyStimulus();
    end
    next_weight_tile_i = 1'b0;

    // Three tiles with no consumes until cycle 100
    doReset();
    startRun(16'h0100, 8'd3);
    contig = 0;
    idle_rd = 0;
    for (int c = 1; c <= 102; c++) begin
      if (c <= 64 && weight_rd_en_o && weight_rd_addr_o == AW'(32'h100 + c - 1)) contig++;
      if (c >= 65 && c <= 100 && !weight_rd_en_o) idle_rd++;
      if (c == 65) expectVal("b2b_tile1_buf", int'(weight_wr_buf_o), 1);
      if (c == 101) begin
        expectVal("b2b_resume_rd", int'(weight_rd_en_o), 1);
        expectVal("b2b_resume_addr", int'(weight_rd_addr_o), 'h140);
      end
      if (c == 102) begin
        expectVal("b2b_tile2_row", int'(weight_wr_row_o), 0);
        expectVal("b2b_tile2_buf", int'(weight_wr_buf_o), 0);
      end
      next_weight_tile_i = (c == 100);
      applyStimulus();
    end
    next_weight_tile_i = 1'b0;
    expectVal("b2b_contig_reads", contig, 64);
    expectVal("b2b_wait_idle", idle_rd, 36);

    // Consume coinciding with tile 1's last-row write
    doReset();
    startRun(16'h0200, 8'd2);
    rdy_high = 0;
    for (int c = 1; c <= 84; c++) begin
      if (c >= 34 && c <= 80 && compute_weights_rdy_o) rdy_high++;
      if (c == 81) expectVal("sim_rdy_low", int'(compute_weights_rdy_o), 0);
      if (c == 82) expectVal("sim_done", int'(done_o), 1);
      next_weight_tile_i = (c == 65 || c == 80);
      applyStimulus();
    end
    next_weight_tile_i = 1'b0;
    expectVal("sim_rdy_steady", rdy_high, 47);

    // Underflow mid-fetch, sticky until the next start
    doReset();
    startRun(16'h0300, 8'd1);
    for (int c = 1; c <= 46; c++) begin
      if (c == 11 || c == 39 || c == 43) expectVal("uf_sticky", int'(underflow_o), 1);
      if (c == 34) expectVal("uf_rdy", int'(compute_weights_rdy_o), 1);
      if (c == 45) expectVal("uf_cleared", int'(underflow_o), 0);
      next_weight_tile_i = (c == 10 || c == 40);
      start_i = (c == 44);
      applyStimulus();
    end
    next_weight_tile_i = 1'b0;
    start_i = 1'b0;

    // Zero tiles
    doReset();
    startRun(16'h0400, 8'd0);
    busy_seen = 0;
    done_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      if (busy_o) busy_seen++;
      if (done_o) done_seen++;
      if (c == 1) expectVal("zero_done_c1", int'(done_o), 1);
      applyStimulus();
    end
    expectVal("zero_busy", busy_seen, 0);
    expectVal("zero_done_once", done_seen, 1);

    // Reset at row 10, then restart
    doReset();
    startRun(16'h0400, 8'd2);
    for (int c = 1; c <= 14; c++) begin
      if (c == 11) expectVal("rst_row10_addr", int'(weight_rd_addr_o), 'h40A);
      if (c == 12) expectVal("rst_outputs_zero",
        int'({weight_rd_en_o, weight_rd_addr_o, weight_wr_en_o, weight_wr_row_o,
              weight_wr_buf_o, compute_weights_rdy_o, busy_o, done_o, underflow_o}), 0);
      if (c == 14) begin
        expectVal("rst_restart_rd", int'(weight_rd_en_o), 1);
        expectVal("rst_restart_addr", int'(weight_rd_addr_o), 'h400);
      end
      rst_i = !(c == 11);
      start_i = (c == 13);
      applyStimulus();
    end
    start_i = 1'b0;
    rst_i = 1'b1;

    // Randomized traffic, including address wrap and a mid-run reset
    doReset();
    done_seen = 0;
    for (int c = 0; c < 4000; c++) begin
      start_i            = ($urandom_range(0, 24) == 0);
      W_base_addr_i      = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : AW'($urandom);
      num_tiles_i        = TW'($urandom_range(0, 4));
      next_weight_tile_i = ($urandom_range(0, 5) == 0);
      rst_i              = !(c == 2000);
      applyStimulus();
      if (done_o) done_seen++;
    end
    start_i = 1'b0;
    next_weight_tile_i = 1'b0;
    rst_i = 1'b1;
    expectVal("rand_done_seen", int'(done_seen > 0), 1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/weight_fetch_control_unit.md
Name: weight_fetch_control_unit

Overview:
- Sequences weight-tile loads from the on-chip weight memory into the two weight buffers (ping/pong) of the MUL_SIZE x MUL_SIZE systolic MAC array.
- Sits ahead of the compute control unit:
  - drives compute_weights_rdy_o to it;
  - consumes its next_weight_tile pulse to free a buffer.
- Keeps at most two tiles resident and issues row reads back-to-back whenever a buffer is free.

Parameters:
- MUL_SIZE, 32, array dimension; rows per weight tile (power of two).
- ADDR_W, 16, weight memory address width.
- TILES_W, 8, width of the tile-count field.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset (0 = reset).
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- W_base_addr_i  in  ADDR_W  address of row 0 of tile 0; latched on start.
- num_tiles_i  in  TILES_W  number of tiles to load; latched on start.
- next_weight_tile_i  in  1  pulse from compute control; the current tile is consumed and its buffer freed.
- weight_rd_en_o  out  1  weight memory read enable; fixed 1-cycle read latency.
- weight_rd_addr_o  out  ADDR_W  read address.
- weight_wr_en_o  out  1  write returned row into the MAC weight buffer.
- weight_wr_row_o  out  $clog2(MUL_SIZE)  destination row.
- weight_wr_buf_o  out  1  destination buffer (0 = ping, 1 = pong).
- compute_weights_rdy_o  out  1  at least one fully loaded tile is resident.
- busy_o  out  1  not IDLE.
- done_o  out  1  one-cycle pulse: all tiles loaded and consumed.
- underflow_o  out  1  sticky: consume pulse seen with no full tile.

Behaviour:
- Reset (rst_i = 0 at a clock edge): all outputs 0, all counters 0, state IDLE, buf pointer 0. A reset mid-operation aborts without draining; an in-flight read is discarded.
- Counters:
  - tile_cntr: tiles issued.
  - row_cntr: 0..MUL_SIZE-1.
  - reserved_q: 0..2; +1 when a tile's row-0 read issues, −1 on a valid consume.
  - full_q: 0..2; +1 when a tile's last row is written, −1 on a valid consume.
- If increment and decrement coincide, the net change is 0.
- States:
  - IDLE: busy_o = 0. On start_i:
    - latch inputs and clear underflow_o;
    - go to FETCH if num_tiles_i != 0;
    - otherwise pulse done_o next cycle and stay IDLE.
  - FETCH:
    - weight_rd_en_o = 1;
    - weight_rd_addr_o = base + tile_cntr*MUL_SIZE + row_cntr (modulo 2^ADDR_W, wraps silently);
    - row_cntr increments each cycle.
    - At row_cntr == MUL_SIZE-1:
      - tile_cntr++ and buf pointer toggles.
      - If tile_cntr+1 == num_tiles → DRAIN.
      - Else if reserved_q (after this cycle's consume) < 2 → continue FETCH with row 0 of the next tile the very next cycle (no bubble).
      - Else → WAIT_FREE.
  - WAIT_FREE: weight_rd_en_o = 0. The cycle a consume pulse arrives, go to FETCH; the first read issues the following cycle.
  - DRAIN: wait until full_q == 0 and no write is pending, then pulse done_o for one cycle → IDLE. Consume pulses are still accepted.
- Write path: one cycle after each read, weight_wr_en_o = 1 with that read's row and buf (delayed copies).
- compute_weights_rdy_o = (full_q != 0), registered. It deasserts the cycle after the consume that empties full_q.
- Consume rules:
  - next_weight_tile_i with full_q == 0 is ignored for both counters and sets underflow_o until the next start/reset.
  - In IDLE, next_weight_tile_i is ignored and does not flag.
- start_i while busy_o is ignored.
- Latency from a start pulse sampled at edge 0:
  - first read at cycle 1;
  - last row of tile 0 written at cycle MUL_SIZE+1;
  - compute_weights_rdy_o high at cycle MUL_SIZE+2.

Decomposition:
- tpu_package additions:
  - MUL_SIZE (already present);
  - WEIGHT_ADDR_W;
  - typedef enum weight_fetch_state_t {IDLE, FETCH, WAIT_FREE, DRAIN};
  - typedef logic [$clog2(MUL_SIZE)-1:0] row_idx_t.
- Single module; no sub-module needed. The 1-cycle read-return delay line is inline.

Test Plan:
- Single tile: start, base=0x0100, num_tiles=1 →
  - reads 0x0100..0x011F on cycles 1..32;
  - writes rows 0..31 to buf 0 on cycles 2..33;
  - rdy high at cycle 34;
  - consume at 40 → rdy low at 41, done_o at 42, busy_o low.
- Back-to-back: num_tiles=3, no consumes →
  - tiles 0,1 read contiguously (64 reads, addresses 0x0100..0x013F, buf 0 then 1);
  - then WAIT_FREE with rd_en=0.
  - A consume at cycle 100 → tile 2 row 0 read at cycle 101, addr 0x0140, buf 0.
- Simultaneous: consume pulse on the same cycle as tile 1's last-row write → full_q stays 1 and rdy stays high without a glitch.
- Underflow: consume while full_q=0 mid-FETCH → underflow_o=1 sticky; counters unchanged; a new start clears it.
- num_tiles=0: start → no reads; done_o pulses exactly once, on cycle 1; busy_o never rises.
- Reset mid-FETCH at row 10: rst_i=0 for one edge → all outputs 0 next cycle, state IDLE; a subsequent start reloads from row 0.
